bram_port_master: RTL
=====================

Name: bram_port_master

Overview:
- Requester-side controller that drives a single-port BRAM port (enable/write-enable, one-cycle registered read, read data forced to zero while enable is low).
- Accepts word requests from a client over a valid/ready handshake. Requests carry a per-byte write strobe.
- Partial-strobe writes are done as read-modify-write, because the BRAM has no byte enables.
- Returns one response per request. Sits between the pipeline's memory stage and the BRAM macros.

Parameters:
- WIDTH_BITS, 32, data word width; must be a multiple of 8.
- ADDR_BITS, 6, word address width.
- DEPTH, 64, number of valid words; used only with the optional feature.
- STRB_BITS, WIDTH_BITS/8, localparam, byte strobe width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready at clock edge
- i_req_we  in  1  1=write, 0=read
- i_req_addr  in  ADDR_BITS  word address
- i_req_wstrb  in  STRB_BITS  byte strobes (writes only)
- i_req_wd  in  WIDTH_BITS  write data
- o_rsp_valid  out  1  response valid, held until taken
- i_rsp_ready  in  1  client takes response
- o_rsp_rd  out  WIDTH_BITS  read data (0 for writes)
- o_rsp_err  out  1  address error (optional feature)
- o_bram_en  out  1  BRAM enable
- o_bram_we  out  1  BRAM write enable
- o_bram_addr  out  ADDR_BITS  BRAM address
- o_bram_wd  out  WIDTH_BITS  BRAM write data
- i_bram_rd  in  WIDTH_BITS  BRAM read data (valid the cycle after an enabled read)

Behaviour:
- Registered FSM with states IDLE, RD, CAP, WR, RSP. The BRAM-side outputs are decoded from the state register plus latched request registers only; there is no combinational path from i_req_* to o_bram_*.
- Reset: state=IDLE and all request/response registers cleared. Outputs after reset: o_req_ready=1, o_rsp_valid=0, o_rsp_rd=0, o_rsp_err=0, o_bram_en=0, o_bram_we=0, o_bram_addr=0, o_bram_wd=0.
- IDLE: o_req_ready=1. On valid&ready, latch we/addr/wstrb/wd, then branch:
  - read -> RD
  - write with wstrb all ones -> WR
  - write with wstrb nonzero partial -> RD
  - write with wstrb all zero -> RSP; no BRAM access
- RD: en=1, we=0, addr=latched addr -> CAP.
- CAP: en=0; sample i_bram_rd this cycle.
  - Read: rsp_rd <= i_bram_rd -> RSP.
  - RMW: merge register <= per byte (wstrb[b] ? wd byte b : i_bram_rd byte b) -> WR.
- WR: en=1, we=1, addr=latched, wd = merge register (partial) or latched wd (full); rsp_rd <= 0 -> RSP.
- RSP: o_rsp_valid=1 with o_rsp_rd/o_rsp_err stable. On i_rsp_ready -> IDLE. o_req_ready=0 in every state except IDLE, so at most one request is outstanding.
- Latency, accept edge = T, o_rsp_valid asserted from cycle:
  - read: T+3
  - full write: T+2
  - partial write: T+4
  - zero-strobe write: T+1
- o_bram_en=0 in IDLE, CAP and RSP, so the BRAM read port idles at zero.
- Mid-operation reset drops the request in flight; a WR not yet reached performs no write. A reset asserted during WR wins: en/we are 0 from the next cycle.
- Request fields are ignored while o_req_ready=0. The response stays valid indefinitely while i_rsp_ready=0.

Optional Feature:
- Macro BRAM_PORT_MASTER_ADDRCHK_EN.
- Defined: an accepted request with i_req_addr >= DEPTH goes directly to RSP with o_rsp_err=1, o_rsp_rd=0, and no BRAM enable in any cycle.
- Undefined: no check is made; o_rsp_err is tied 0 and all addresses access the BRAM.

Test Plan:
- Reset, then full write addr 5 data 0xDEADBEEF, then read addr 5 -> write response at T+2; read gives rsp_rd=0xDEADBEEF at T+3; exactly one en&we pulse, at addr 5.
- Mem[3]=0x11223344; write wstrb=4'b0101 wd=0xAABBCCDD addr 3, then read -> read returns 0x11BB33DD; bus shows RD, idle, WR sequence.
- Read with i_rsp_ready held low 5 cycles -> o_rsp_valid and data stable, o_req_ready=0, and a second request held on i_req_valid is not accepted until the response is taken.
- Write with wstrb=0 -> response at T+1, o_bram_en never asserted.
- Assert i_rst in CAP of a partial write to addr 7 -> no write to addr 7, all outputs at reset values next cycle, subsequent read returns the old value.
- With BRAM_PORT_MASTER_ADDRCHK_EN and DEPTH=48, read addr 50 -> o_rsp_err=1, rsp_rd=0, no BRAM enable; addr 47 reads normally with err=0.

Source files
------------

// File: rtl/bram_port_master.sv
// Requester-side controller for a single-port BRAM; byte-strobed writes become read-modify-write. Optional range check: BRAM_PORT_MASTER_ADDRCHK_EN.
// Latency from accept to o_rsp_valid: read 3, full write 2, partial write 4, zero-strobe write 1 cycles.
// One request in flight: o_req_ready only in IDLE; the response is held until i_rsp_ready.
module bram_port_master #(
    parameter int WIDTH_BITS = 32,
    parameter int ADDR_BITS  = 6,
    parameter int DEPTH      = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [ADDR_BITS-1:0]      i_req_addr,
    input  logic [WIDTH_BITS/8-1:0]   i_req_wstrb,
    input  logic [WIDTH_BITS-1:0]     i_req_wd,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [WIDTH_BITS-1:0]     o_rsp_rd,
    output logic                      o_rsp_err,
    output logic                      o_bram_en,
    output logic                      o_bram_we,
    output logic [ADDR_BITS-1:0]      o_bram_addr,
    output logic [WIDTH_BITS-1:0]     o_bram_wd,
    input  logic [WIDTH_BITS-1:0]     i_bram_rd
);
    localparam int STRB_BITS = WIDTH_BITS / 8;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RSP} state_t;

    state_t                 state, state_nxt;
    logic                   we_q;
    logic                   partial_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [STRB_BITS-1:0]   wstrb_q;
    logic [WIDTH_BITS-1:0]  wd_q;
    logic [WIDTH_BITS-1:0]  merge_q;
    logic [WIDTH_BITS-1:0]  merged;
    logic [WIDTH_BITS-1:0]  rsp_rd_q;
    logic                   rsp_err_q;
    logic                   accept;
    logic                   addr_bad;

    assign accept = (state == S_IDLE) && i_req_valid;

`ifdef BRAM_PORT_MASTER_ADDRCHK_EN
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);
    assign addr_bad = ({1'b0, i_req_addr} >= DEPTH_L);
`else
    localparam int UNUSED_DEPTH = DEPTH;
    logic [31:0] unused_depth;
    assign unused_depth = UNUSED_DEPTH;
    assign addr_bad     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (addr_bad)               state_nxt = S_RSP;
                else if (!i_req_we)         state_nxt = S_RD;
                else if (&i_req_wstrb)      state_nxt = S_WR;
                else if (|i_req_wstrb)      state_nxt = S_RD;
                else                        state_nxt = S_RSP;
            end
            S_RD:   state_nxt = S_CAP;
            S_CAP:  state_nxt = we_q ? S_WR : S_RSP;
            S_WR:   state_nxt = S_RSP;
            S_RSP:  if (i_rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Unstrobed bytes keep the value just read back from the BRAM.
    always_comb begin
        merged = '0;
        for (int b = 0; b < STRB_BITS; b++)
            merged[8*b +: 8] = wstrb_q[b] ? wd_q[8*b +: 8] : i_bram_rd[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q      <= 1'b0;
            partial_q <= 1'b0;
            addr_q    <= '0;
            wstrb_q   <= '0;
            wd_q      <= '0;
            merge_q   <= '0;
            rsp_rd_q  <= '0;
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            we_q      <= i_req_we;
            partial_q <= ~&i_req_wstrb;
            addr_q    <= i_req_addr;
            wstrb_q   <= i_req_wstrb;
            wd_q      <= i_req_wd;
            rsp_rd_q  <= '0;
            rsp_err_q <= addr_bad;
        end else if (state == S_CAP) begin
            if (we_q) merge_q  <= merged;
            else      rsp_rd_q <= i_bram_rd;
        end else if (state == S_WR) begin
            rsp_rd_q <= '0;
        end
    end

    always_comb begin
        o_req_ready = (state == S_IDLE);
        o_rsp_valid = (state == S_RSP);
        o_rsp_rd    = rsp_rd_q;
        o_rsp_err   = rsp_err_q;
        o_bram_en   = (state == S_RD) || (state == S_WR);
        o_bram_we   = (state == S_WR);
        o_bram_addr = addr_q;
        o_bram_wd   = '0;
        if (state == S_WR) o_bram_wd = partial_q ? merge_q : wd_q;
    end
endmodule
